// File: rtl/qam_dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qam_dsp_pkg
// Description : Shared constants and types for the DSP output stage capture path.
// Revision    : 1.0 - initial release
// ============================================================================
package qam_dsp_pkg;

  localparam int CAPTURE_DEPTH  = 128;
  localparam int CAPTURE_ADDR_W = $clog2(CAPTURE_DEPTH);
  localparam int SAMPLE_W       = 12;
  localparam int SPI_FRAME_W    = 16;
  localparam int SPI_CMD_W      = 8;
  localparam int CMD_RD         = 7;

  typedef enum logic [2:0] {
    RB_IDLE   = 3'd0,
    RB_CMD    = 3'd1,
    RB_FETCH  = 3'd2,
    RB_DATA   = 3'd3,
    RB_IGNORE = 3'd4
  } rb_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_input_sync
// Description : Synchronizers and edge detectors for the SPI responder pins.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  // CS resets to "asserted" so a CS already low at reset release is not seen as a fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync[0] <= sclk;
      r_cs_sync[0]   <= cs_n;
      r_mosi_sync[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sclk_sync[i] <= r_sclk_sync[i-1];
        r_cs_sync[i]   <= r_cs_sync[i-1];
        r_mosi_sync[i] <= r_mosi_sync[i-1];
      end
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
  assign cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
  assign cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;
  assign mosi_s    = r_mosi_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/capture_readback_spi.sv
`default_nettype none
// ============================================================================
// Module      : capture_readback_spi
// Description : SPI mode-0 responder streaming the sample capture store out on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_readback_spi
  import qam_dsp_pkg::*;
#(
  parameter int ADDR_W      = CAPTURE_ADDR_W,
  parameter int DATA_W      = SAMPLE_W,
  parameter int FRAME_W     = SPI_FRAME_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              capture_lock,
  output logic              word_done
);

  localparam logic [2:0] c_IDLE   = 3'(RB_IDLE);
  localparam logic [2:0] c_CMD    = 3'(RB_CMD);
  localparam logic [2:0] c_FETCH  = 3'(RB_FETCH);
  localparam logic [2:0] c_DATA   = 3'(RB_DATA);
  localparam logic [2:0] c_IGNORE = 3'(RB_IGNORE);

  localparam int c_CNT_W = $clog2((FRAME_W > SPI_CMD_W) ? FRAME_W : SPI_CMD_W);
  localparam logic [c_CNT_W-1:0] c_CMD_LAST  = c_CNT_W'(SPI_CMD_W - 1);
  localparam logic [c_CNT_W-1:0] c_WORD_LAST = c_CNT_W'(FRAME_W - 1);

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_mosi_s;

  spi_input_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_input_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (spi_sclk),
    .cs_n      (spi_cs_n),
    .mosi      (spi_mosi),
    .sclk_rise (w_sclk_rise),
    .sclk_fall (w_sclk_fall),
    .cs_fall   (w_cs_fall),
    .cs_rise   (w_cs_rise),
    .mosi_s    (w_mosi_s)
  );

  logic [2:0]           r_state;
  logic [c_CNT_W-1:0]   r_bit_cnt;
  logic [SPI_CMD_W-2:0] r_cmd;
  logic [FRAME_W-1:0]   r_shift;
  logic [FRAME_W-1:0]   r_next;
  logic                 r_rd_vld;
  logic                 r_reload;
  logic                 r_miso;
  logic                 r_rd_en;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_lock;
  logic                 r_word_done;

  logic [SPI_CMD_W-1:0] w_cmd;
  logic [FRAME_W-1:0]   w_rd_word;

  assign w_cmd     = {r_cmd, w_mosi_s};
  assign w_rd_word = FRAME_W'(mem_rd_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_IDLE;
      r_bit_cnt   <= '0;
      r_cmd       <= '0;
      r_shift     <= '0;
      r_next      <= '0;
      r_rd_vld    <= 1'b0;
      r_reload    <= 1'b0;
      r_miso      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_lock      <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_rd_en     <= 1'b0;
      r_word_done <= 1'b0;
      r_rd_vld    <= r_rd_en;
      if (r_rd_vld) begin
        r_next <= w_rd_word;
      end

      if ((r_state != c_IDLE) && w_cs_rise) begin
        r_state  <= c_IDLE;
        r_miso   <= 1'b0;
        r_lock   <= 1'b0;
        r_reload <= 1'b0;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (w_cs_fall) begin
              r_state   <= c_CMD;
              r_bit_cnt <= '0;
              r_lock    <= 1'b1;
              r_miso    <= 1'b0;
              r_reload  <= 1'b0;
            end
          end
          c_CMD: begin
            if (w_sclk_rise) begin
              r_cmd     <= w_cmd[SPI_CMD_W-2:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == c_CMD_LAST) begin
                r_bit_cnt <= '0;
                if (w_cmd[CMD_RD]) begin
                  r_state <= c_FETCH;
                  r_addr  <= w_cmd[ADDR_W-1:0];
                  r_rd_en <= 1'b1;
                end else begin
                  r_state <= c_IGNORE;
                end
              end
            end
          end
          c_FETCH: begin
            if (r_rd_vld) begin
              r_shift <= w_rd_word;
              r_miso  <= w_rd_word[FRAME_W-1];
              r_state <= c_DATA;
            end
          end
          c_DATA: begin
            if (w_sclk_rise) begin
              if (r_bit_cnt == c_WORD_LAST) begin
                r_bit_cnt   <= '0;
                r_word_done <= 1'b1;
                r_addr      <= r_addr + 1'b1;
                r_rd_en     <= 1'b1;
                r_reload    <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else if (w_sclk_fall) begin
              // The fall closing the command byte arrives with no bit consumed yet and must not shift.
              if (r_reload) begin
                r_shift  <= r_next;
                r_miso   <= r_next[FRAME_W-1];
                r_reload <= 1'b0;
              end else if (r_bit_cnt != '0) begin
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                r_miso  <= r_shift[FRAME_W-2];
              end
            end
          end
          c_IGNORE: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= c_IDLE;
            r_miso  <= 1'b0;
            r_lock  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_miso     = r_miso;
  assign mem_rd_en    = r_rd_en;
  assign mem_addr     = r_addr;
  assign capture_lock = r_lock;
  assign word_done    = r_word_done;

endmodule
`default_nettype wire

// File: tb/tb_capture_readback_spi.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_readback_spi
// Description : Directed self-checking bench for capture_readback_spi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_readback_spi;

  logic        clk;
  logic        rst;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_rd_en;
  logic [6:0]  mem_addr;
  logic [11:0] mem_rd_data;
  logic        capture_lock;
  logic        word_done;

  capture_readback_spi dut (
    .clk          (clk),
    .rst          (rst),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .capture_lock (capture_lock),
    .word_done    (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] mem [0:127];
  int          wd_cnt = 0;
  int          rd_cnt = 0;
  logic [6:0]  rd_hist [0:2];

  // Capture store: data valid one clock after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr];
      rd_cnt      <= rd_cnt + 1;
      rd_hist[0]  <= mem_addr;
      rd_hist[1]  <= rd_hist[0];
      rd_hist[2]  <= rd_hist[1];
    end
    if (word_done) wd_cnt <= wd_cnt + 1;
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] rx [0:127];
  int          rx_n;
  logic        lock_bad;
  logic        miso_cmd_bad;
  int          wd0;
  int          rd0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI mode-0 transaction: command byte then ndata data bits, each phase h clocks.
  task automatic spi_run(input logic [7:0] cmd, input int ndata, input int h, input bit close);
    logic [15:0] sh;
    sh = '0;
    rx_n = 0;
    lock_bad = 1'b0;
    miso_cmd_bad = 1'b0;
    spi_cs_n = 1'b0;
    tick(h);
    for (int i = 0; i < 8 + ndata; i++) begin
      spi_mosi = (i < 8) ? cmd[7-i] : 1'b0;
      tick(h);
      if (capture_lock !== 1'b1) lock_bad = 1'b1;
      if (i >= 8) begin
        sh = {sh[14:0], spi_miso};
        if (((i - 8) % 16) == 15 && rx_n < 128) begin
          rx[rx_n] = sh;
          rx_n++;
        end
      end else if (spi_miso !== 1'b0) begin
        miso_cmd_bad = 1'b1;
      end
      spi_sclk = 1'b1;
      tick(h);
      spi_sclk = 1'b0;
    end
    if (close) begin
      tick(h);
      spi_cs_n = 1'b1;
      tick(2 * h + 4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tick(3);
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", mem_rd_en); end
    checks++; if (mem_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", mem_addr); end
    checks++; if (capture_lock !== 1'b0) begin errors++; $display("FAIL reset_lock got %b exp 0", capture_lock); end
    checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL reset_word_done got %b exp 0", word_done); end
    rst = 1'b1;
    tick(8);
    checks++; if (capture_lock !== 1'b0) begin errors++; $display("FAIL reset_idle_lock got %b exp 0", capture_lock); end
  endtask

  task automatic test_read_basic();
    wd0 = wd_cnt; rd0 = rd_cnt;
    spi_run(8'h80, 32, 4, 1'b1);
    checks++; if (rx[0] !== 16'h0000) begin errors++; $display("FAIL basic_w0 got %h exp 0000", rx[0]); end
    checks++; if (rx[1] !== 16'h0003) begin errors++; $display("FAIL basic_w1 got %h exp 0003", rx[1]); end
    checks++; if (wd_cnt - wd0 !== 2) begin errors++; $display("FAIL basic_word_done got %0d exp 2", wd_cnt - wd0); end
    checks++; if (rd_cnt - rd0 !== 3) begin errors++; $display("FAIL basic_reads got %0d exp 3", rd_cnt - rd0); end
    checks++; if (rd_hist[2] !== 7'd0 || rd_hist[1] !== 7'd1 || rd_hist[0] !== 7'd2) begin
      errors++; $display("FAIL basic_addr_seq got %0d %0d %0d exp 0 1 2", rd_hist[2], rd_hist[1], rd_hist[0]);
    end
    checks++; if (miso_cmd_bad !== 1'b0) begin errors++; $display("FAIL basic_miso_cmd got %b exp 0", miso_cmd_bad); end
    checks++; if (lock_bad !== 1'b0) begin errors++; $display("FAIL basic_lock_held got %b exp 0", lock_bad); end
    checks++; if (capture_lock !== 1'b0) begin errors++; $display("FAIL basic_lock_after got %b exp 0", capture_lock); end
  endtask

  task automatic test_wrap();
    spi_run(8'hFF, 32, 4, 1'b1);
    checks++; if (rx[0] !== 16'h017D) begin errors++; $display("FAIL wrap_w0 got %h exp 017D", rx[0]); end
    checks++; if (rx[1] !== 16'h0000) begin errors++; $display("FAIL wrap_w1 got %h exp 0000", rx[1]); end
  endtask

  task automatic test_ignore();
    wd0 = wd_cnt; rd0 = rd_cnt;
    spi_run(8'h05, 16, 4, 1'b1);
    checks++; if (rx[0] !== 16'h0000) begin errors++; $display("FAIL ignore_miso got %h exp 0000", rx[0]); end
    checks++; if (rd_cnt - rd0 !== 0) begin errors++; $display("FAIL ignore_reads got %0d exp 0", rd_cnt - rd0); end
    checks++; if (lock_bad !== 1'b0) begin errors++; $display("FAIL ignore_lock got %b exp 0", lock_bad); end
    checks++; if (wd_cnt - wd0 !== 0) begin errors++; $display("FAIL ignore_word_done got %0d exp 0", wd_cnt - wd0); end
  endtask

  task automatic test_abort();
    wd0 = wd_cnt;
    spi_run(8'h8A, 5, 4, 1'b0);
    spi_cs_n = 1'b1;
    tick(4);
    checks++; if (capture_lock !== 1'b0) begin errors++; $display("FAIL abort_lock got %b exp 0", capture_lock); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL abort_miso got %b exp 0", spi_miso); end
    checks++; if (wd_cnt - wd0 !== 0) begin errors++; $display("FAIL abort_word_done got %0d exp 0", wd_cnt - wd0); end
    tick(8);
    wd0 = wd_cnt;
    spi_run(8'h8A, 16, 4, 1'b1);
    checks++; if (rx[0] !== 16'h001E) begin errors++; $display("FAIL abort_retry got %h exp 001E", rx[0]); end
    checks++; if (wd_cnt - wd0 !== 1) begin errors++; $display("FAIL abort_retry_wd got %0d exp 1", wd_cnt - wd0); end
  endtask

  task automatic test_reset_mid();
    spi_run(8'h85, 14, 4, 1'b0);
    checks++; if (mem_addr !== 7'd5 || capture_lock !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got addr %0d lock %b exp 5 1", mem_addr, capture_lock);
    end
    #3 rst = 1'b0;
    #1;
    checks++; if (mem_addr !== 7'd0 || capture_lock !== 1'b0 || spi_miso !== 1'b0 || mem_rd_en !== 1'b0 || word_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got addr %0d lock %b miso %b rd %b wd %b exp all 0",
                         mem_addr, capture_lock, spi_miso, mem_rd_en, word_done);
    end
    tick(2);
    rst = 1'b1;
    tick(2);
    wd0 = wd_cnt; rd0 = rd_cnt;
    for (int i = 0; i < 16; i++) begin
      spi_sclk = 1'b1; tick(4);
      spi_sclk = 1'b0; tick(4);
    end
    checks++; if (rd_cnt - rd0 !== 0) begin errors++; $display("FAIL rstmid_reads got %0d exp 0", rd_cnt - rd0); end
    checks++; if (capture_lock !== 1'b0) begin errors++; $display("FAIL rstmid_lock got %b exp 0", capture_lock); end
    spi_cs_n = 1'b1;
    tick(8);
    wd0 = wd_cnt;
    spi_run(8'h85, 16, 4, 1'b1);
    checks++; if (rx[0] !== 16'h000F) begin errors++; $display("FAIL rstmid_fresh got %h exp 000F", rx[0]); end
    checks++; if (wd_cnt - wd0 !== 1) begin errors++; $display("FAIL rstmid_fresh_wd got %0d exp 1", wd_cnt - wd0); end
  endtask

  task automatic test_stream();
    logic [6:0] a;
    for (int i = 0; i < 128; i++) mem[i] = 12'($urandom_range(0, 4095));
    wd0 = wd_cnt;
    spi_run(8'hC0, 128 * 16, 4, 1'b1);
    for (int k = 0; k < 128; k++) begin
      a = 7'(64 + k);
      checks++;
      if (rx[k] !== {4'b0000, mem[a]}) begin
        errors++; $display("FAIL stream_w%0d got %h exp %h", k, rx[k], {4'b0000, mem[a]});
      end
    end
    checks++; if (wd_cnt - wd0 !== 128) begin errors++; $display("FAIL stream_word_done got %0d exp 128", wd_cnt - wd0); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 12'(i * 3);
    test_reset();
    test_read_basic();
    test_wrap();
    test_ignore();
    test_abort();
    test_reset_mid();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/capture_readback_spi.md
# capture_readback_spi

SPI responder that reads out the 128-entry sample capture store (first 64 and last 64 filtered samples of each packet) of the DSP output stage. It sits between the capture RAM's read port and the board SPI pins, runs entirely on the DSP clock, and oversamples SCLK/CS. While a transaction is active it raises a lock so the capture writer holds the snapshot stable.

## Interface
Parameters:
- ADDR_W, 7, capture store address width (128 entries)
- DATA_W, 12, sample width
- FRAME_W, 16, SPI data word width; sample is right-justified, upper bits zero
- SYNC_STAGES, 2, synchronizer flops on spi_sclk, spi_cs_n, spi_mosi

Ports:
- clk  in  1  DSP clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
- spi_cs_n  in  1  chip select, active low
- spi_mosi  in  1  command in, MSB first
- spi_miso  out  1  data out, MSB first
- mem_rd_en  out  1  one-cycle read strobe to capture store
- mem_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 clk after mem_rd_en
- capture_lock  out  1  high while a transaction is in progress
- word_done  out  1  one-cycle pulse per fully shifted data word

## Operation
- Inputs pass through SYNC_STAGES flops; rising/falling SCLK edges and CS fall/rise detected on synchronized values.
- Transaction: CS low; 8-bit command {rd, start_addr[6:0]} on MOSI, sampled on SCLK rising edges; then continuous FRAME_W-bit words on MISO until CS high.
- States: IDLE, CMD, FETCH, DATA, IGNORE.
- IDLE: CS fall -> CMD; bit_cnt cleared, capture_lock set.
- CMD: shift MOSI on each SCLK rise; on 8th rise: rd=1 -> FETCH, mem_addr=start_addr, mem_rd_en pulses; rd=0 -> IGNORE.
- FETCH: next cycle load shift register with zero-extended mem_rd_data, drive MSB on spi_miso -> DATA.
- DATA: each SCLK fall shifts next bit onto spi_miso. On the FRAME_W-th SCLK rise of a word: word_done pulses, mem_addr increments, mem_rd_en pulses; returned data is loaded on the following SCLK fall (which drives the new word's MSB).
- Address wraps 127 -> 0; no error, no stop.
- IGNORE: spi_miso held 0, no memory reads, until CS rise.
- CS rise (synchronized) in any state -> IDLE next cycle: partial word discarded, spi_miso 0, capture_lock 0, no word_done for a partial word.
- SCLK edges while CS high are ignored.
- spi_miso is 0 in IDLE, CMD, IGNORE.

## Timing
- Reset values: spi_miso 0, mem_rd_en 0, mem_addr 0, capture_lock 0, word_done 0, state IDLE. Reset mid-transaction aborts immediately; after release the block waits for a fresh CS fall (CS already low at release is ignored until it rises).
- SCLK frequency <= clk/8; each SCLK phase >= 4 clk cycles.
- Input-to-edge-detect latency: SYNC_STAGES + 1 clk.
- Command rise detect -> mem_rd_en: same cycle; spi_miso valid with word MSB 2 clk later, before the 8th SCLK fall.
- capture_lock rises 1 clk after synchronized CS fall, falls 1 clk after synchronized CS rise.

## Structure
- Shared package qam_dsp_pkg: CAPTURE_DEPTH=128, CAPTURE_ADDR_W, SAMPLE_W=12, SPI_FRAME_W=16, CMD_RD bit position, readback state enum.
- Sub-module spi_input_sync: SYNC_STAGES synchronizer plus edge detect for sclk and cs_n, and synchronizer for mosi; outputs sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s.

## Test plan
- RAM model preloaded with mem[a]=a*3; command 0x80, read 2 words -> MISO 0x0000, 0x0003; two word_done pulses; mem_addr 0 then 1 then 2.
- Command 0xFF, 2 words -> 0x017D then 0x0000 (wrap 127->0).
- Command 0x05 (rd=0), 16 SCLKs -> MISO constant 0, mem_rd_en never asserted, capture_lock high throughout CS low.
- Command 0x8A, CS high after 5 data bits -> no word_done, IDLE and capture_lock 0 within SYNC_STAGES+2 clk; following 0x8A transaction returns 0x001E.
- rst asserted mid-word with CS low -> all outputs 0 immediately; after release with CS still low, SCLK toggles produce no reads until CS rises and falls again.
- SCLK at exactly clk/8 with random mem_rd_data over 128 consecutive words -> every word matches model bit-exactly, 128 word_done pulses.
